priority_arbiter_rr: RTL

- Parametrised, registered successor to the combinational 4:2 priority encoder.
- Arbitrates N request lines and produces a registered grant index plus one-hot grant.
- Grant is held by a valid/ack handshake.
- Fixed-priority or round-robin mode, selected by parameter.
- Sits between N requesters and a shared resource, such as a bus port or shared register file.

---
 rtl/priority_arbiter_rr.sv | 73 +++++++
 1 files changed

// File: rtl/priority_arbiter_rr.sv
// priority_arbiter_rr: registered N-way arbiter with valid/ack hold, fixed-priority or round-robin search
module priority_arbiter_rr #(
  parameter int N = 8,
  parameter int RR_MODE = 0,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] req,
  input  logic         ack,
  output logic         grant_valid,
  output logic [W-1:0] grant_idx,
  output logic [N-1:0] grant_onehot,
  output logic [W-1:0] ptr
);
  logic         r_valid;
  logic [W-1:0] r_idx;
  logic [N-1:0] r_onehot;
  logic [W-1:0] r_ptr;
  logic         w_release;
  logic         w_load;
  logic [W-1:0] w_ptr_nxt;
  logic [W-1:0] w_base;
  logic [W-1:0] w_cand;
  logic [W-1:0] w_sel;
  logic         w_found;

  assign w_release = r_valid && ack;
  assign w_ptr_nxt = (w_release && RR_MODE != 0) ? ((r_idx == '0) ? W'(N-1) : r_idx - 1'b1) : r_ptr;
  assign w_base    = (RR_MODE != 0) ? w_ptr_nxt : W'(N-1);
  assign w_load    = en && w_found && (!r_valid || ack);

  // Descending search from w_base with wrap at N; later (higher-priority) hits overwrite earlier ones
  always_comb begin
    w_found = 1'b0;
    w_sel = '0;
    w_cand = '0;
    for (int k = N-1; k >= 0; k--) begin
      w_cand = (int'(w_base) >= k) ? W'(int'(w_base) - k) : W'(int'(w_base) + N - k);
      if (req[w_cand]) begin
        w_found = 1'b1;
        w_sel = w_cand;
      end
    end
  end

  // Grant state: load on idle or back-to-back after ack, hold otherwise, drop on bare ack
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_idx    <= '0;
      r_onehot <= '0;
      r_ptr    <= W'(N-1);
    end else begin
      r_ptr <= w_ptr_nxt;
      if (w_load) begin
        r_valid  <= 1'b1;
        r_idx    <= w_sel;
        r_onehot <= {{(N-1){1'b0}}, 1'b1} << w_sel;
      end else if (w_release) begin
        r_valid  <= 1'b0;
        r_idx    <= '0;
        r_onehot <= '0;
      end
    end
  end

  assign grant_valid  = r_valid;
  assign grant_idx    = r_idx;
  assign grant_onehot = r_onehot;
  assign ptr          = r_ptr;
endmodule
